// File: rtl/func_arbiter.sv
// Round-robin arbiter sharing one multi-cycle func unit between two requesters.
// Runs each job with a cycle budget, and on timeout aborts the job and resets the unit.
module func_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [7:0]  a0_i,
  input  logic [7:0]  b0_i,
  input  logic [7:0]  a1_i,
  input  logic [7:0]  b1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [23:0] y0_o,
  output logic [23:0] y1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic        busy_o,
  output logic [1:0]  grant_o,
  output logic        f_start_o,
  output logic [7:0]  f_a_o,
  output logic [7:0]  f_b_o,
  output logic        f_rst_o,
  input  logic        f_busy_i,
  input  logic [23:0] f_y_i
);

  localparam logic [15:0] TIMEOUT_C = TIMEOUT[15:0];

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] count_reg;
  logic [1:0]  grant_reg;
  logic        last_reg;
  logic        timeout_reg;
  logic [7:0]  fa_reg, fb_reg;
  logic        pick1;
  logic        run_done, run_timeout;
  logic [1:0]  ack, err;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1 = req1_i && (!req0_i || !last_reg);

  // The unit raises busy one cycle after start, so busy is meaningless in RUN cycle 1.
  assign run_done    = (count_reg >= 16'd2) && !f_busy_i;
  assign run_timeout = !run_done && (count_reg == TIMEOUT_C);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req0_i || req1_i) state_next = START;
      START:   state_next = RUN;
      RUN:     if (run_done || run_timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_reg != IDLE);
    f_start_o = (state_reg == START);
    f_rst_o   = rst_i || ((state_reg == DONE) && timeout_reg);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg   <= '0;
      grant_reg   <= '0;
      last_reg    <= 1'b1;
      timeout_reg <= 1'b0;
      fa_reg      <= '0;
      fb_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0_i || req1_i) begin
            grant_reg <= pick1 ? 2'b10 : 2'b01;
            fa_reg    <= pick1 ? a1_i : a0_i;
            fb_reg    <= pick1 ? b1_i : b0_i;
          end
        end
        START: count_reg <= 16'd1;
        RUN: begin
          if (run_timeout)   timeout_reg <= 1'b1;
          else if (!run_done) count_reg  <= count_reg + 16'd1;
        end
        DONE: begin
          grant_reg   <= '0;
          last_reg    <= grant_reg[1];
          count_reg   <= '0;
          timeout_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Per-requester result register and completion strobes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [23:0] y_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        y_reg <= '0;
      end else if (state_reg == RUN && grant_reg[gi]) begin
        if (run_done)         y_reg <= f_y_i;
        else if (run_timeout) y_reg <= '0;
      end
    end

    assign ack[gi] = (state_reg == DONE) && grant_reg[gi];
    assign err[gi] = ack[gi] && timeout_reg;
  end

  assign ack0_o  = ack[0];
  assign ack1_o  = ack[1];
  assign err0_o  = err[0];
  assign err1_o  = err[1];
  assign y0_o    = g_req[0].y_reg;
  assign y1_o    = g_req[1].y_reg;
  assign grant_o = grant_reg;
  assign f_a_o   = fa_reg;
  assign f_b_o   = fb_reg;

endmodule

// File: tb/tb_func_arbiter.sv
// Directed bench for func_arbiter with a behavioural func unit (y = a^3 + isqrt(b)).
// Vector table for single jobs, plus sequences for tie, back-to-back, and reset mid-run.
module tb_func_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ack0, ack1, err0, err1, busy;
  logic [23:0] y0, y1;
  logic [1:0]  grant;
  logic        f_start, f_rst, f_busy;
  logic [7:0]  f_a, f_b;
  logic [23:0] f_y;

  always #5 clk = ~clk;

  func_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .ack0_o(ack0), .ack1_o(ack1), .y0_o(y0), .y1_o(y1),
    .err0_o(err0), .err1_o(err1), .busy_o(busy), .grant_o(grant),
    .f_start_o(f_start), .f_a_o(f_a), .f_b_o(f_b), .f_rst_o(f_rst),
    .f_busy_i(f_busy), .f_y_i(f_y)
  );

  // Func unit model: busy rises the cycle after start and lasts busy_len cycles.
  int unsigned busy_len;
  logic        stuck;
  int          mcnt;

  function automatic logic [23:0] ref_func(input logic [7:0] a, input logic [7:0] b);
    int unsigned av, bv, r;
    av = a;
    bv = b;
    r  = 0;
    while ((r + 1) * (r + 1) <= bv) r++;
    return 24'(av * av * av + r);
  endfunction

  always @(posedge clk) begin
    if (f_rst) begin
      f_busy <= 1'b0;
      mcnt   <= 0;
      f_y    <= '0;
    end else if (f_start) begin
      f_busy <= 1'b1;
      mcnt   <= busy_len;
      f_y    <= ref_func(f_a, f_b);
    end else if (f_busy && !stuck) begin
      mcnt <= mcnt - 1;
      if (mcnt <= 1) f_busy <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_yv [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0, r1;
    logic [7:0]  a0, b0, a1, b1;
    int unsigned len;
    logic        stk;
    int          port;
    logic [23:0] y;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl [8];

  task automatic run_job(input string tag, input vec_t v);
    int n;
    logic got;
    logic [7:0] ea;
    a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    busy_len = v.len; stuck = v.stk;
    req0 = v.r0; req1 = v.r1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (ack0 || ack1) got = 1'b1;
    end
    chk({tag, ".ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      ea = (v.port == 0) ? v.a0 : v.a1;
      exp_yv[v.port] = v.y;
      chk({tag, ".ack"},   32'({ack1, ack0}), (v.port == 0) ? 32'd1 : 32'd2);
      chk({tag, ".grant"}, 32'(grant),        (v.port == 0) ? 32'd1 : 32'd2);
      chk({tag, ".y"},     32'((v.port == 0) ? y0 : y1), 32'(v.y));
      chk({tag, ".y_other"}, 32'((v.port == 0) ? y1 : y0), 32'(exp_yv[1 - v.port]));
      chk({tag, ".err"},   32'({err1, err0}), v.err ? ((v.port == 0) ? 32'd1 : 32'd2) : 32'd0);
      chk({tag, ".f_rst"}, 32'(f_rst), 32'(v.err));
      chk({tag, ".f_a"},   32'(f_a), 32'(ea));
      chk({tag, ".latency"}, 32'(n), 32'(v.lat));
    end
    $display("job %s port=%0d y0=%0d y1=%0d err=%0d cycles=%0d", tag, v.port, y0, y1, err0 | err1, n);
    req0 = 1'b0; req1 = 1'b0; stuck = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ctl"},  32'({busy, grant, ack0, ack1, err0, err1, f_start}), 32'd0);
    chk({tag, ".y0"},   32'(y0), 32'd0);
    chk({tag, ".y1"},   32'(y1), 32'd0);
    chk({tag, ".f_ab"}, 32'({f_a, f_b}), 32'd0);
    chk({tag, ".f_rst"}, 32'(f_rst), 32'd1);
  endtask

  task automatic wait_ack(input string tag, output logic got);
    int n;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (ack0 || ack1) got = 1'b1;
    end
    chk({tag, ".ack_seen"}, 32'(got), 32'd1);
  endtask

  task automatic tie_sequence();
    logic got;
    rst = 1'b1;
    tick();
    a0 = 8'd2; b0 = 8'd0; a1 = 8'd3; b1 = 8'd1;
    busy_len = 1; stuck = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b0;
    exp_yv[0] = '0; exp_yv[1] = '0;
    for (int k = 0; k < 4; k++) begin
      wait_ack("tie", got);
      if (got) begin
        chk("tie.order", 32'({ack1, ack0}), (k % 2 == 0) ? 32'd1 : 32'd2);
        chk("tie.y", 32'((k % 2 == 0) ? y0 : y1), (k % 2 == 0) ? 32'd8 : 32'd28);
        $display("tie ack %0d: ack0=%0d ack1=%0d y0=%0d y1=%0d", k, ack0, ack1, y0, y1);
        tick();
        chk("tie.ack_pulse", 32'({ack1, ack0}), 32'd0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    exp_yv[0] = 24'd8; exp_yv[1] = 24'd28;
    repeat (6) tick();
  endtask

  task automatic back_to_back();
    logic got;
    a1 = 8'd4; b1 = 8'd4; busy_len = 2;
    req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack("b2b", got);
      if (got) begin
        chk("b2b.ack", 32'({ack1, ack0}), 32'd2);
        chk("b2b.y1", 32'(y1), 32'd66);
        $display("b2b ack %0d: y1=%0d", k, y1);
        if (k == 2) req1 = 1'b0;
        tick();
        chk("b2b.idle", 32'({busy, grant}), 32'd0);
        tick();
        chk("b2b.restart", 32'(f_start), (k == 2) ? 32'd0 : 32'd1);
      end
    end
    exp_yv[1] = 24'd66;
    tick();
  endtask

  task automatic reset_mid_run();
    vec_t v;
    a0 = 8'd9; b0 = 8'd9; stuck = 1'b1; busy_len = 1;
    req0 = 1'b1;
    tick();
    tick();
    tick();
    chk("midrst.running", 32'({busy, grant}), 32'd5);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst.async");
    req0 = 1'b0; stuck = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst.no_ack", 32'({ack1, ack0}), 32'd0);
    end
    rst = 1'b0;
    exp_yv[0] = '0; exp_yv[1] = '0;
    tick();
    v = '{1'b0, 1'b1, 8'd0, 8'd0, 8'd15, 8'd15, 3, 1'b0, 1, 24'd3378, 1'b0, 6};
    run_job("midrst.req1", v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int unsigned len;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    busy_len = 1; stuck = 1'b0;
    exp_yv[0] = '0; exp_yv[1] = '0;

    //         r0    r1    a0      b0      a1      b1      len stk port  y               err   lat
    tbl[0] = '{1'b1, 1'b0, 8'd15,  8'd15,  8'd0,   8'd0,   3,  1'b0, 0, 24'd3378,     1'b0, 6};
    tbl[1] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd2,   8'd9,   1,  1'b0, 1, 24'd11,       1'b0, 4};
    tbl[2] = '{1'b1, 1'b1, 8'd3,   8'd4,   8'd5,   8'd16,  2,  1'b0, 0, 24'd29,       1'b0, 5};
    tbl[3] = '{1'b1, 1'b1, 8'd3,   8'd4,   8'd5,   8'd16,  2,  1'b0, 1, 24'd129,      1'b0, 5};
    tbl[4] = '{1'b1, 1'b0, 8'd240, 8'd240, 8'd0,   8'd0,   6,  1'b0, 0, 24'd13824015, 1'b0, 9};
    tbl[5] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd255, 8'd255, 7,  1'b0, 1, 24'd16581390, 1'b0, 10};
    tbl[6] = '{1'b1, 1'b0, 8'd1,   8'd1,   8'd0,   8'd0,   1,  1'b1, 0, 24'd0,        1'b1, 10};
    tbl[7] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd1,   8'd100, 1,  1'b0, 1, 24'd11,       1'b0, 4};

    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("reset.release_f_rst", 32'(f_rst), 32'd0);
    chk("reset.idle", 32'({busy, grant, f_start}), 32'd0);

    for (int i = 0; i < 8; i++) run_job($sformatf("vec%0d", i), tbl[i]);

    tie_sequence();
    back_to_back();
    reset_mid_run();

    for (int i = 0; i < 17; i++) begin
      for (int j = 0; j < 17; j++) begin
        len = 32'((i * 3 + j) % 6 + 1);
        v.port = (i + j) % 2;
        v.r0   = (v.port == 0);
        v.r1   = (v.port == 1);
        v.a0   = 8'(15 * i);
        v.b0   = 8'(15 * j);
        v.a1   = 8'(15 * i);
        v.b1   = 8'(15 * j);
        v.len  = len;
        v.stk  = 1'b0;
        v.y    = ref_func(8'(15 * i), 8'(15 * j));
        v.err  = 1'b0;
        v.lat  = 2 + ((len + 1 > 2) ? int'(len) + 1 : 2);
        run_job($sformatf("sweep_a%0d_b%0d", 15 * i, 15 * j), v);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/func_arbiter.md
FUNC_ARBITER -- requirements
Module: func_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum number of RUN cycles allowed before a job is aborted (legal range 1..65535).
REQ-002 clk_i  in  1  single clock; all registers update on its rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 req0_i, req1_i  in  1 each  job request from requester 0 and requester 1.
REQ-005 a0_i, b0_i, a1_i, b1_i  in  8 each  operands for each requester; held stable while that requester's req is high.
REQ-006 ack0_o, ack1_o  out  1 each  one-cycle pulse marking job completion for that requester.
REQ-007 y0_o, y1_o  out  24 each  registered result per requester.
REQ-008 err0_o, err1_o  out  1 each  asserted together with ack when the job timed out.
REQ-009 busy_o  out  1  high in every state except IDLE.
REQ-010 grant_o  out  2  one-hot owner of the func unit: bit0 = requester 0, bit1 = requester 1; 00 when IDLE.
REQ-011 f_start_o  out  1  drives the func unit's start_i.
REQ-012 f_a_o, f_b_o  out  8 each  drive the func unit's a_i and b_i.
REQ-013 f_rst_o  out  1  drives the func unit's rst_i.
REQ-014 f_busy_i  in  1  func unit's busy_o.
REQ-015 f_y_i  in  24  func unit's y_o.

Function
REQ-016 The block SHALL have the states IDLE, START, RUN and DONE.
REQ-017 IDLE->START SHALL occur on the first edge at which req0_i or req1_i is high.
- On that edge, the winner is latched into grant_o and its operands into f_a_o/f_b_o.
REQ-018 Arbitration SHALL be round-robin.
- Single request: that requester wins.
- Both requesting: the requester not served last wins.
- The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-019 In START, f_start_o SHALL be high for exactly one cycle; START->RUN unconditionally.
REQ-020 In RUN, the block SHALL count cycles from 1.
- f_busy_i sampled low: RUN->DONE, and f_y_i is captured into the owner's y register.
- Count reaches TIMEOUT with f_busy_i still high: RUN->DONE; owner's y is set to 0 and its err is flagged.
REQ-021 The func unit asserts busy_o on the cycle after start_i.
- The block SHALL ignore f_busy_i on the first RUN cycle.
- Completion is therefore detected no earlier than the second RUN cycle.
REQ-022 In DONE, the owner's ack SHALL pulse for one cycle, with err high only on timeout.
- DONE->IDLE unconditionally; grant_o clears and the last-served pointer updates to the owner.
REQ-023 On timeout, f_rst_o SHALL pulse high for the DONE cycle.
- Otherwise f_rst_o SHALL equal rst_i, combinationally.
REQ-024 The minimum latency from a request sampled at IDLE to ack SHALL be 4 cycles (START, RUN x2, DONE).
REQ-025 If the owner drops req after grant, the job SHALL still complete and ack SHALL still pulse.
- If a requester drops req before grant, it SHALL not be served.
REQ-026 A requester holding req high through its ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-027 yN_o SHALL hold its value until the next completion for requester N; the other requester's y SHALL be unaffected.
REQ-028 f_a_o/f_b_o SHALL remain stable from START through DONE.

Reset
REQ-029 While rst_i is high, the following SHALL all be 0 immediately (asynchronously):
- state = IDLE
- grant_o, busy_o, ack0_o, ack1_o, err0_o, err1_o, f_start_o
- y0_o, y1_o, f_a_o, f_b_o, RUN counter
REQ-030 During reset the last-served pointer SHALL be 1 and f_rst_o SHALL be 1.
REQ-031 Reset asserted mid-job SHALL abandon the job with no ack; the first job after release SHALL restart from IDLE.

Verification
REQ-032 Single job: req0 with a0=15, b0=15; func model busy for 3 cycles -> f_start one pulse; ack0 with y0_o=3378, err0=0; y1_o unchanged.
REQ-033 Tie: req0 and req1 both high from reset release -> requester 0 served first, then requester 1; with both held, service alternates 0,1,0,1.
REQ-034 Back-to-back: req1 held continuously with req0 low -> requester 1 served repeatedly, one IDLE cycle between ack1 and the next f_start.
REQ-035 Timeout: TIMEOUT=8 and f_busy_i stuck high -> ack with err=1 and y=0 on the 8th RUN cycle; f_rst_o pulses in the same cycle; next job completes normally.
REQ-036 Reset mid-RUN: rst_i asserted during RUN -> all outputs 0 at once, no ack; after release, req1 alone is served correctly.
REQ-037 Scoreboard: sweep a,b = 0,15,...,240 on both ports -> each y equals a^3 + floor(sqrt(b)), e.g. a=240, b=240 gives 13824015.
